ram_param: RTL and testbench

- Parametrised successor to the fixed 8-word x 16-bit register-file RAM.
- Generalises word width and depth. Adds:
  - a registered read port with a read-valid strobe;
  - a selectable read-during-write policy;
  - a sequenced clear-all operation with a busy flag;
  - asynchronous reset of the whole array.
- Sits as the general-purpose scratch memory behind the datapath and replaces per-size RAM variants.

---
 rtl/ram_param_pkg.sv | 13 +
 rtl/ram_clr_seq.sv | 61 ++++++
 rtl/ram_param.sv | 71 +++++++
 tb/tb_ram_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_param_pkg.sv
// Shared definitions for the parametrised scratch RAM: clear-sequencer state
// encoding and the default geometry reused by the register file and bus decoder.
package ram_param_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AW    = 3;

endpackage : ram_param_pkg

// File: rtl/ram_clr_seq.sv
// IDLE/CLEAR sequencer: on a clr request, sweeps every word address once,
// issuing one zero-write strobe per cycle while busy is high.
module ram_clr_seq
  import ram_param_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam int DEPTH = 2 ** AW;
  // One extra counter bit keeps the terminal compare free of wrap ambiguity.
  localparam logic [AW:0] LAST = (AW + 1)'(DEPTH - 1);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  state_t      state;
  logic [AW:0] cnt;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = cnt[AW-1:0];

endmodule : ram_clr_seq

// File: rtl/ram_param.sv
// Parametrised single-port scratch RAM with registered read, selectable
// read-during-write policy, sequenced clear-all and asynchronous array reset.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = DEF_AW,
  parameter bit WR_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             e,
  input  logic             w,
  input  logic             r,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] DIn,
  input  logic             clr,
  output logic [WIDTH-1:0] DOut,
  output logic             rd_valid,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             host_en;
  logic             host_we;
  logic             host_re;

  ram_clr_seq #(.AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst_     (rst_),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A host access sampled alongside clr, or during a sweep, is dropped.
  assign host_en = e && !busy && !clr;
  assign host_we = host_en && w;
  assign host_re = host_en && r;

  // NOTE: the array is in the async reset on purpose -- reset must zero every
  // word at once, so this stays flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (host_we) begin
      mem[addr] <= DIn;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      DOut     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= host_re;
      if (host_re) begin
        // Same-address write bypass only when write-first is selected.
        DOut <= (WR_FIRST && host_we) ? DIn : mem[addr];
      end
    end
  end

endmodule : ram_param

// File: tb/tb_ram_param.sv
// Directed scoreboard bench: two 16x8 instances (read-first / write-first)
// driven in lockstep, plus an 8-bit x 32-word instance.
module tb_ram_param;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_   = 1'b1;
  logic        e = 1'b0, w = 1'b0, r = 1'b0, clr = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] din  = '0;
  logic [15:0] dout_a, dout_b;
  logic        rv_a, rv_b, busy_a, busy_b;

  logic        e_c = 1'b0, w_c = 1'b0, r_c = 1'b0, clr_c = 1'b0;
  logic [4:0]  addr_c = '0;
  logic [7:0]  din_c  = '0;
  logic [7:0]  dout_c;
  logic        rv_c, busy_c;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_busy;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  qc[$];
  logic [15:0] model[8];

  ram_param #(.WIDTH(16), .AW(3), .WR_FIRST(1'b0)) u_a (
    .clk(clk), .rst_(rst_), .e(e), .w(w), .r(r), .addr(addr), .DIn(din),
    .clr(clr), .DOut(dout_a), .rd_valid(rv_a), .busy(busy_a));

  ram_param #(.WIDTH(16), .AW(3), .WR_FIRST(1'b1)) u_b (
    .clk(clk), .rst_(rst_), .e(e), .w(w), .r(r), .addr(addr), .DIn(din),
    .clr(clr), .DOut(dout_b), .rd_valid(rv_b), .busy(busy_b));

  ram_param #(.WIDTH(8), .AW(5), .WR_FIRST(1'b0)) u_c (
    .clk(clk), .rst_(rst_), .e(e_c), .w(w_c), .r(r_c), .addr(addr_c), .DIn(din_c),
    .clr(clr_c), .DOut(dout_c), .rd_valid(rv_c), .busy(busy_c));

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    e = 1'b0; w = 1'b0; r = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    e = 1'b1; w = 1'b1; r = 1'b0; addr = a; din = d;
    model[a] = d;
    step();
    idle_in();
  endtask

  task automatic rd(input logic [2:0] a);
    e = 1'b1; w = 1'b0; r = 1'b1; addr = a;
    qa.push_back(model[a]);
    qb.push_back(model[a]);
    step();
    check("rd_latency", 64'(rv_a), 64'(1'b1));
    idle_in();
  endtask

  // Scoreboard side: every rd_valid pulse must consume one queued expectation.
  always @(negedge clk) begin
    check("rv_match", 64'(rv_a), 64'(rv_b));
    if (rv_a) begin
      check("rd_pending", 64'(qa.size() != 0), 64'(1'b1));
      if (qa.size() != 0) begin
        check("dout_a", 64'(dout_a), 64'(qa.pop_front()));
        check("dout_b", 64'(dout_b), 64'(qb.pop_front()));
      end
    end
    if (rv_c) begin
      check("rd_pending_c", 64'(qc.size() != 0), 64'(1'b1));
      if (qc.size() != 0) check("dout_c", 64'(dout_c), 64'(qc.pop_front()));
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Asynchronous reset with the clock stopped.
    #3 rst_ = 1'b0;
    #1;
    check("rst_dout", 64'(dout_a), 64'(0));
    check("rst_rv", 64'(rv_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_busy_c", 64'(busy_c), 64'(0));
    check("rst_dout_c", 64'(dout_c), 64'(0));
    clk_en = 1'b1;
    step();
    step();
    rst_ = 1'b1;
    step();
    for (int i = 0; i < 8; i++) rd(3'(i));
    step();

    // Basic write / read, then a disabled write.
    wr(3'd3, 16'hA5A5);
    wr(3'd7, 16'h1234);
    rd(3'd3);
    check("rd3_direct", 64'(dout_a), 64'(16'hA5A5));
    rd(3'd7);
    check("rd7_direct", 64'(dout_a), 64'(16'h1234));
    step();
    check("rv_single_cycle", 64'(rv_a), 64'(0));
    e = 1'b0; w = 1'b1; addr = 3'd3; din = 16'hFFFF;
    step();
    idle_in();
    rd(3'd3);

    // Read-during-write on the same address.
    wr(3'd2, 16'h0001);
    e = 1'b1; w = 1'b1; r = 1'b1; addr = 3'd2; din = 16'hBEEF;
    qa.push_back(16'h0001);
    qb.push_back(16'hBEEF);
    model[2] = 16'hBEEF;
    step();
    idle_in();
    check("rdw_old", 64'(dout_a), 64'(16'h0001));
    check("rdw_new", 64'(dout_b), 64'(16'hBEEF));
    rd(3'd2);

    // Clear sweep: fill, pulse clr with a colliding access, count busy.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * (i + 1)));
    rd(3'd7);
    clr = 1'b1; e = 1'b1; w = 1'b1; r = 1'b1; addr = 3'd0; din = 16'h7777;
    step();
    idle_in();
    n_busy = 0;
    for (int k = 0; k < 100 && busy_a; k++) begin
      n_busy++;
      if (k == 2) begin
        e = 1'b1; w = 1'b1; r = 1'b1; addr = 3'd5; din = 16'hFFFF;
      end else if (k == 3) begin
        clr = 1'b1;
      end else begin
        idle_in();
      end
      step();
    end
    idle_in();
    check("busy_cycles", 64'(n_busy), 64'(8));
    check("busy_b_done", 64'(busy_b), 64'(0));
    check("dout_hold", 64'(dout_a), 64'(16'h8888));
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 8; i++) rd(3'(i));
    step();

    // Reset in the middle of a sweep.
    wr(3'd4, 16'h4444);
    clr = 1'b1;
    step();
    idle_in();
    step();
    step();
    step();
    check("mid_busy_before", 64'(busy_a), 64'(1));
    #2 rst_ = 1'b0;
    #1;
    check("mid_busy_async", 64'(busy_a), 64'(0));
    check("mid_dout_rst", 64'(dout_a), 64'(0));
    rst_ = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    step();
    check("mid_idle", 64'(busy_a), 64'(0));
    wr(3'd1, 16'h00C3);
    rd(3'd1);
    rd(3'd4);
    step();

    // Wide-address, narrow-word instance.
    e_c = 1'b1; w_c = 1'b1; addr_c = 5'd31; din_c = 8'h5A;
    step();
    w_c = 1'b0; r_c = 1'b1;
    qc.push_back(8'h5A);
    step();
    check("c_rd_latency", 64'(rv_c), 64'(1));
    e_c = 1'b0; r_c = 1'b0; clr_c = 1'b1;
    step();
    clr_c = 1'b0;
    n_busy = 0;
    for (int k = 0; k < 200 && busy_c; k++) begin
      n_busy++;
      step();
    end
    check("c_busy_cycles", 64'(n_busy), 64'(32));
    e_c = 1'b1; r_c = 1'b1; addr_c = 5'd31;
    qc.push_back(8'h00);
    step();
    e_c = 1'b0; r_c = 1'b0;
    step();
    step();

    check("qa_drained", 64'(qa.size()), 64'(0));
    check("qc_drained", 64'(qc.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ram_param
